// File: rtl/t_ff_pkg.sv
// rtl/t_ff_pkg.sv - shared mode encoding for the T flip-flop counter bank
package t_ff_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_BANK = 2'd0,
    MODE_UP   = 2'd1,
    MODE_DOWN = 2'd2,
    MODE_HOLD = 2'd3
  } mode_t;

endpackage

// File: rtl/t_ff_cell.sv
// rtl/t_ff_cell.sv - single edge-triggered T flip-flop with parallel load
module t_ff_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic rst_val,
  input  logic t,
  input  logic ld,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= rst_val;
    end else if (ld) begin
      q <= d;
    end else if (t) begin
      q <= ~q;
    end
  end

endmodule

// File: rtl/t_ff_counter.sv
// rtl/t_ff_counter.sv - T flip-flop bank / up-down counter; T_FF_CNT_SAT_EN selects saturating count
module t_ff_counter
  import t_ff_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  t_mask,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  output logic [WIDTH-1:0]  q,
  output logic              tc
);

  mode_t            mode_e;
  logic [WIDTH-1:0] t;
  logic             term;
  logic             ones_run;
  logic             zeros_run;

  assign mode_e = mode_t'(mode);

  // Each cell toggles when every lower bit is all-ones (up) or all-zeros (down).
  always_comb begin
    t         = '0;
    term      = 1'b0;
    ones_run  = 1'b1;
    zeros_run = 1'b1;
    if (en) begin
      case (mode_e)
        MODE_BANK: t = t_mask;
        MODE_UP: begin
          for (int i = 0; i < WIDTH; i++) begin
            t[i]     = ones_run;
            ones_run = ones_run & q[i];
          end
          term = ones_run;
        end
        MODE_DOWN: begin
          for (int i = 0; i < WIDTH; i++) begin
            t[i]      = zeros_run;
            zeros_run = zeros_run & ~q[i];
          end
          term = zeros_run;
        end
        default: t = '0;
      endcase
    end
`ifdef T_FF_CNT_SAT_EN
    if (term) begin
      t = '0;
    end
`else
`endif
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    t_ff_cell u_cell (
      .clk     (clk),
      .rst_n   (rst_n),
      .rst_val (RST_VAL[g]),
      .t       (t[g]),
      .ld      (load),
      .d       (load_val[g]),
      .q       (q[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tc <= 1'b0;
    end else begin
      tc <= term & ~load;
    end
  end

endmodule

// File: tb/tb_t_ff_counter.sv
// tb/tb_t_ff_counter.sv - scoreboard bench for t_ff_counter at WIDTH=4, RST_VAL=0
module tb_t_ff_counter;
  import t_ff_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  logic [3:0] t_mask;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] q;
  logic       tc;

  int checks = 0;
  int errors = 0;

  logic [3:0] mq;
  logic       mtc;
  logic [3:0] exp_q[$];
  logic       exp_tc[$];
  logic [3:0] eq;
  logic       etc;

  t_ff_counter #(.WIDTH(4), .RST_VAL(4'h0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .t_mask(t_mask),
    .load(load), .load_val(load_val), .q(q), .tc(tc)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout q=%h tc=%b", q, tc);
    $fatal(1, "timeout");
  end

  // Drive one edge of stimulus, advance the reference model, queue its prediction.
  task automatic drive(input logic ld, input logic [3:0] lv, input logic e,
                       input logic [1:0] m, input logic [3:0] tm);
    load = ld; load_val = lv; en = e; mode = m; t_mask = tm;
    if (ld) begin
      mq = lv; mtc = 1'b0;
    end else if (!e || m == 2'd3) begin
      mtc = 1'b0;
    end else if (m == 2'd0) begin
      mq = mq ^ tm; mtc = 1'b0;
    end else if (m == 2'd1) begin
      mtc = (mq == 4'hF);
`ifdef T_FF_CNT_SAT_EN
      if (!mtc) mq = mq + 4'd1;
`else
      mq = mq + 4'd1;
`endif
    end else begin
      mtc = (mq == 4'h0);
`ifdef T_FF_CNT_SAT_EN
      if (!mtc) mq = mq - 4'd1;
`else
      mq = mq - 4'd1;
`endif
    end
    exp_q.push_back(mq);
    exp_tc.push_back(mtc);
    @(posedge clk);
    #1;
  endtask

  task automatic pop_expected();
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_empty got q=%h tc=%b", q, tc);
      eq = 'x; etc = 'x;
    end else begin
      eq  = exp_q.pop_front();
      etc = exp_tc.pop_front();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 0; mode = MODE_HOLD; t_mask = 0; load = 0; load_val = 0;
    mq = 4'h0; mtc = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (q !== 4'h0 || tc !== 1'b0) begin
      errors++; $display("FAIL reset_initial got q=%h tc=%b want q=0 tc=0", q, tc);
    end
    rst_n = 1'b1;
    drive(1'b1, 4'h8, 1'b0, MODE_UP, 4'h0);
    pop_expected();
    drive(1'b0, 4'h0, 1'b1, MODE_UP, 4'h0);
    pop_expected();
    checks++;
    if (q !== eq || q !== 4'h9) begin
      errors++; $display("FAIL reset_precount got q=%h want %h", q, eq);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (q !== 4'h0 || tc !== 1'b0) begin
      errors++; $display("FAIL reset_async got q=%h tc=%b want q=0 tc=0", q, tc);
    end
    mq = 4'h0; mtc = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(1'b1, 4'hF, 1'b0, MODE_UP, 4'h0);
    pop_expected();
    drive(1'b0, 4'h0, 1'b1, MODE_UP, 4'h0);
    pop_expected();
    checks++;
    if (tc !== 1'b1) begin
      errors++; $display("FAIL reset_tc_setup got tc=%b want 1", tc);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (tc !== 1'b0 || q !== 4'h0) begin
      errors++; $display("FAIL reset_tc_clear got q=%h tc=%b want q=0 tc=0", q, tc);
    end
    mq = 4'h0; mtc = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_up_wrap();
    logic [3:0] want_q[3];
    logic       want_tc[3];
`ifdef T_FF_CNT_SAT_EN
    want_q = '{4'hF, 4'hF, 4'hF}; want_tc = '{1'b0, 1'b1, 1'b1};
`else
    want_q = '{4'hF, 4'h0, 4'h1}; want_tc = '{1'b0, 1'b1, 1'b0};
`endif
    drive(1'b1, 4'hE, 1'b0, MODE_UP, 4'h0);
    pop_expected();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 4'h0, 1'b1, MODE_UP, 4'h0);
      pop_expected();
      checks++;
      if (q !== eq || tc !== etc || q !== want_q[i] || tc !== want_tc[i]) begin
        errors++;
        $display("FAIL up_wrap[%0d] got q=%h tc=%b want q=%h tc=%b", i, q, tc, want_q[i], want_tc[i]);
      end
    end
  endtask

  task automatic test_down_wrap();
    logic [3:0] want_q[3];
    logic       want_tc[3];
`ifdef T_FF_CNT_SAT_EN
    want_q = '{4'h0, 4'h0, 4'h0}; want_tc = '{1'b0, 1'b1, 1'b1};
`else
    want_q = '{4'h0, 4'hF, 4'hE}; want_tc = '{1'b0, 1'b1, 1'b0};
`endif
    drive(1'b1, 4'h1, 1'b0, MODE_DOWN, 4'h0);
    pop_expected();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 4'h0, 1'b1, MODE_DOWN, 4'h0);
      pop_expected();
      checks++;
      if (q !== eq || tc !== etc || q !== want_q[i] || tc !== want_tc[i]) begin
        errors++;
        $display("FAIL down_wrap[%0d] got q=%h tc=%b want q=%h tc=%b", i, q, tc, want_q[i], want_tc[i]);
      end
    end
  endtask

  task automatic test_bank();
    drive(1'b1, 4'hA, 1'b0, MODE_BANK, 4'h0);
    pop_expected();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 4'h0, 1'b1, MODE_BANK, 4'h5);
      pop_expected();
      checks++;
      if (q !== eq || tc !== 1'b0 || q !== (i == 0 ? 4'hF : 4'hA)) begin
        errors++; $display("FAIL bank[%0d] got q=%h tc=%b want q=%h tc=0", i, q, tc, eq);
      end
    end
  endtask

  task automatic test_priority();
    drive(1'b1, 4'hF, 1'b0, MODE_UP, 4'h0);
    pop_expected();
    drive(1'b1, 4'h3, 1'b1, MODE_UP, 4'hF);
    pop_expected();
    checks++;
    if (q !== 4'h3 || tc !== 1'b0 || q !== eq) begin
      errors++; $display("FAIL priority_load got q=%h tc=%b want q=3 tc=0", q, tc);
    end
    drive(1'b0, 4'h0, 1'b0, MODE_UP, 4'h0);
    pop_expected();
    checks++;
    if (q !== 4'h3 || tc !== 1'b0) begin
      errors++; $display("FAIL priority_hold got q=%h tc=%b want q=3 tc=0", q, tc);
    end
  endtask

  task automatic test_hold();
    drive(1'b1, 4'hF, 1'b0, MODE_UP, 4'h0);
    pop_expected();
    for (int i = 0; i < 10; i++) begin
      if (i < 5) drive(1'b0, 4'h0, 1'b1, MODE_HOLD, 4'hF);
      else       drive(1'b0, 4'h0, 1'b0, MODE_UP, 4'hF);
      pop_expected();
      checks++;
      if (q !== 4'hF || tc !== 1'b0) begin
        errors++; $display("FAIL hold[%0d] got q=%h tc=%b want q=F tc=0", i, q, tc);
      end
    end
  endtask

  task automatic test_back_to_back();
    int pulses;
    pulses = 0;
    drive(1'b1, 4'h0, 1'b0, MODE_UP, 4'h0);
    pop_expected();
    for (int i = 0; i < 34; i++) begin
      drive(1'b0, 4'h0, 1'b1, MODE_UP, 4'h0);
      pop_expected();
      if (tc === 1'b1) pulses++;
      checks++;
      if (q !== eq || tc !== etc) begin
        errors++; $display("FAIL b2b[%0d] got q=%h tc=%b want q=%h tc=%b", i, q, tc, eq, etc);
      end
    end
    checks++;
`ifdef T_FF_CNT_SAT_EN
    if (pulses != 19) begin
`else
    if (pulses != 2) begin
`endif
      errors++; $display("FAIL b2b_pulse_count got %0d", pulses);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      drive(($urandom_range(0, 7) == 0), 4'($urandom), ($urandom_range(0, 3) != 0),
            2'($urandom), 4'($urandom));
      pop_expected();
      checks++;
      if (q !== eq || tc !== etc) begin
        errors++; $display("FAIL random[%0d] got q=%h tc=%b want q=%h tc=%b", i, q, tc, eq, etc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_bank();
    test_priority();
    test_hold();
    test_back_to_back();
    test_random();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
